// File: rtl/cnt_cmp_arbiter.sv
// Two-requester round-robin arbiter sharing one terminal-count counter.
// Every output is driven straight from a flop, decoded from the next state.
module cnt_cmp_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] limit0,
    input  logic [3:0] limit1,
    input  logic       abort,
    output logic [1:0] grant,
    output logic [1:0] cc_mux,
    output logic       enable_count,
    output logic [3:0] count,
    output logic       ackout,
    output logic       busy
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_RUN     = 3'b010,
        ST_DONE    = 3'b011,
        ST_RELEASE = 3'b100
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       ptr_r;
    logic       ptr_nxt_s;
    logic       owner_r;
    logic       owner_nxt_s;
    logic [3:0] lim_r;
    logic [3:0] lim_nxt_s;
    logic [3:0] count_r;
    logic [3:0] count_nxt_s;
    logic [3:0] count_inc_s;
    logic [3:0] limit_sel_s;
    logic [1:0] owner_code_s;
    logic [1:0] grant_r;
    logic [1:0] grant_nxt_s;
    logic [1:0] cc_mux_r;
    logic [1:0] cc_mux_nxt_s;
    logic       enable_r;
    logic       enable_nxt_s;
    logic       ack_r;
    logic       ack_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;

    assign limit_sel_s  = owner_r ? limit1 : limit0;
    assign count_inc_s  = count_r + 4'd1;
    assign owner_code_s = owner_nxt_s ? 2'b10 : 2'b01;

    assign grant        = grant_r;
    assign cc_mux       = cc_mux_r;
    assign enable_count = enable_r;
    assign count        = count_r;
    assign ackout       = ack_r;
    assign busy         = busy_r;

    // State, datapath and output flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 1'b0;
            owner_r  <= 1'b0;
            lim_r    <= 4'd0;
            count_r  <= 4'd0;
            grant_r  <= 2'b00;
            cc_mux_r <= 2'b00;
            enable_r <= 1'b0;
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            owner_r  <= owner_nxt_s;
            lim_r    <= lim_nxt_s;
            count_r  <= count_nxt_s;
            grant_r  <= grant_nxt_s;
            cc_mux_r <= cc_mux_nxt_s;
            enable_r <= enable_nxt_s;
            ack_r    <= ack_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    // Next-state and datapath update; abort outranks completion in LOAD/RUN
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        lim_nxt_s   = lim_r;
        count_nxt_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (req == 2'b00) begin
                    state_nxt_s = ST_IDLE;
                end else if (req == 2'b11) begin
                    owner_nxt_s = ptr_r;
                    state_nxt_s = ST_LOAD;
                end else begin
                    owner_nxt_s = req[1];
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    ptr_nxt_s   = ~owner_r;
                    state_nxt_s = ST_RELEASE;
                end else begin
                    lim_nxt_s   = limit_sel_s;
                    count_nxt_s = 4'd0;
                    if (limit_sel_s == 4'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    ptr_nxt_s   = ~owner_r;
                    state_nxt_s = ST_RELEASE;
                end else if (count_inc_s == lim_r) begin
                    count_nxt_s = lim_r;
                    state_nxt_s = ST_DONE;
                end else begin
                    count_nxt_s = count_inc_s;
                end
            end
            ST_DONE: begin
                ptr_nxt_s   = ~owner_r;
                state_nxt_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (req[owner_r] == 1'b0) begin
                    count_nxt_s = 4'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                count_nxt_s = 4'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flops present it on entry
    always_comb begin
        grant_nxt_s  = 2'b00;
        cc_mux_nxt_s = 2'b00;
        enable_nxt_s = 1'b0;
        ack_nxt_s    = 1'b0;
        busy_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_LOAD: begin
                grant_nxt_s  = owner_code_s;
                cc_mux_nxt_s = owner_code_s;
                busy_nxt_s   = 1'b1;
            end
            ST_RUN: begin
                grant_nxt_s  = owner_code_s;
                cc_mux_nxt_s = owner_code_s;
                enable_nxt_s = 1'b1;
                busy_nxt_s   = 1'b1;
            end
            ST_DONE: begin
                grant_nxt_s  = owner_code_s;
                cc_mux_nxt_s = 2'b11;
                ack_nxt_s    = 1'b1;
                busy_nxt_s   = 1'b1;
            end
            ST_RELEASE: begin
                busy_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cnt_cmp_arbiter.sv
// Self-checking bench for cnt_cmp_arbiter against a phase-level reference model.
module tb_cnt_cmp_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] limit0 = 4'd0;
    logic [3:0] limit1 = 4'd0;
    logic       abort = 1'b0;
    logic [1:0] grant;
    logic [1:0] cc_mux;
    logic       enable_count;
    logic [3:0] count;
    logic       ackout;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3, PH_REL = 4;
    int         m_ph;
    bit         m_owner;
    bit         m_ptr;
    int         m_left;
    logic [3:0] m_count;

    cnt_cmp_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .limit0(limit0), .limit1(limit1),
        .abort(abort), .grant(grant), .cc_mux(cc_mux), .enable_count(enable_count),
        .count(count), .ackout(ackout), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_ph = PH_IDLE; m_owner = 1'b0; m_ptr = 1'b0; m_left = 0; m_count = 4'd0;
    endfunction

    // One clock edge of the behavioural model: a transaction is a phase plus cycles left
    function automatic void model_step();
        int lim;
        case (m_ph)
            PH_IDLE: if (req != 2'b00) begin
                m_owner = (req == 2'b11) ? m_ptr : req[1];
                m_ph = PH_LOAD;
            end
            PH_LOAD: if (abort) begin
                m_ptr = !m_owner; m_ph = PH_REL;
            end else begin
                lim = m_owner ? int'(limit1) : int'(limit0);
                m_count = 4'd0;
                m_left = lim;
                m_ph = (lim == 0) ? PH_DONE : PH_RUN;
            end
            PH_RUN: if (abort) begin
                m_ptr = !m_owner; m_ph = PH_REL;
            end else begin
                m_count = m_count + 4'd1;
                m_left = m_left - 1;
                if (m_left == 0) m_ph = PH_DONE;
            end
            PH_DONE: begin
                m_ptr = !m_owner; m_ph = PH_REL;
            end
            PH_REL: if (req[m_owner] == 1'b0) begin
                m_count = 4'd0; m_ph = PH_IDLE;
            end
            default: m_ph = PH_IDLE;
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [1:0] g, c;
        logic e, a, b;
        g = 2'b00; c = 2'b00; e = 1'b0; a = 1'b0;
        b = (m_ph != PH_IDLE);
        if (m_ph == PH_LOAD || m_ph == PH_RUN || m_ph == PH_DONE) g = m_owner ? 2'b10 : 2'b01;
        if (m_ph == PH_LOAD || m_ph == PH_RUN) c = g;
        if (m_ph == PH_RUN) e = 1'b1;
        if (m_ph == PH_DONE) begin c = 2'b11; a = 1'b1; end
        return {g, c, e, m_count, a, b};
    endfunction

    function automatic logic [10:0] obs();
        return {grant, cc_mux, enable_count, count, ackout, busy};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] r);
        @(negedge clock);
        req = r; abort = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        req = 2'b11; limit0 = 4'd2; limit1 = 4'd2;
        #1;
        n_checks++;
        if (obs() !== 11'd0) begin
            n_errors++; $display("FAIL reset_async got=%b exp=%b", obs(), 11'd0);
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (obs() !== 11'd0) begin
            n_errors++; $display("FAIL reset_held got=%b exp=%b", obs(), 11'd0);
        end
        @(negedge clock);
        model_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_errors++; $display("FAIL reset_first_grant got=%b exp=01", grant);
        end
    endtask

    task automatic test_single();
        logic [3:0] seen[$];
        logic [3:0] exp_seq[3];
        int en_cyc = 0, acks = 0;
        logic prev_en;
        exp_seq = '{4'd1, 4'd2, 4'd3};
        apply_reset(2'b00);
        limit0 = 4'd3; limit1 = 4'd9; req = 2'b01;
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_errors++; $display("FAIL single_grant got=%b exp=01", grant);
        end
        prev_en = enable_count;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_vec()) begin
                n_errors++; $display("FAIL single_model t=%0t got=%b exp=%b", $time, obs(), exp_vec());
            end
            if (prev_en) seen.push_back(count);
            if (enable_count) en_cyc++;
            if (ackout) begin
                acks++;
                n_checks++;
                if (cc_mux !== 2'b11) begin
                    n_errors++; $display("FAIL single_ack_mux got=%b exp=11", cc_mux);
                end
                req = 2'b00;
            end
            prev_en = enable_count;
        end
        n_checks++;
        if (en_cyc != 3 || acks != 1) begin
            n_errors++; $display("FAIL single_counts en=%0d ack=%0d exp en=3 ack=1", en_cyc, acks);
        end
        n_checks++;
        if (seen.size() != 3 || seen[0] !== exp_seq[0] || seen[1] !== exp_seq[1] || seen[2] !== exp_seq[2]) begin
            n_errors++; $display("FAIL single_count_seq got=%p exp=1,2,3", seen);
        end
        n_checks++;
        if (busy !== 1'b0 || count !== 4'd0) begin
            n_errors++; $display("FAIL single_idle busy=%b count=%0d exp busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] gq[$];
        logic [1:0] prev_g = 2'b00;
        apply_reset(2'b11);
        limit0 = 4'd2; limit1 = 4'd1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_vec()) begin
                n_errors++; $display("FAIL rr_model t=%0t got=%b exp=%b", $time, obs(), exp_vec());
            end
            if (grant != 2'b00 && prev_g == 2'b00) gq.push_back(grant);
            if (ackout && grant == 2'b01) req = 2'b10;
            else if (ackout && grant == 2'b10) req = 2'b00;
            prev_g = grant;
        end
        n_checks++;
        if (gq.size() < 2 || gq[0] !== 2'b01 || gq[1] !== 2'b10) begin
            n_errors++; $display("FAIL rr_order got=%p exp=01,10", gq);
        end
    endtask

    task automatic test_zero_limit();
        int ack_at = -1;
        logic en_seen = 1'b0;
        apply_reset(2'b00);
        limit0 = 4'd7; limit1 = 4'd0; req = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_vec()) begin
                n_errors++; $display("FAIL zero_model t=%0t got=%b exp=%b", $time, obs(), exp_vec());
            end
            if (enable_count) en_seen = 1'b1;
            if (ackout) begin
                if (ack_at < 0) ack_at = i;
                n_checks++;
                if (count !== 4'd0) begin
                    n_errors++; $display("FAIL zero_ack_count got=%0d exp=0", count);
                end
                req = 2'b00;
            end
        end
        n_checks++;
        if (en_seen !== 1'b0 || ack_at != 2) begin
            n_errors++; $display("FAIL zero_timing en_seen=%b ack_at=%0d exp en_seen=0 ack_at=2", en_seen, ack_at);
        end
    endtask

    task automatic test_abort();
        int acks = 0;
        apply_reset(2'b00);
        limit0 = 4'd15; limit1 = 4'd4; req = 2'b01;
        for (int i = 0; i < 20 && !(enable_count && count == 4'd5); i++) begin
            tick();
            n_checks++;
            if (obs() !== exp_vec()) begin
                n_errors++; $display("FAIL abort_model t=%0t got=%b exp=%b", $time, obs(), exp_vec());
            end
            if (ackout) acks++;
        end
        abort = 1'b1;
        limit0 = 4'd2;
        tick();
        abort = 1'b0;
        n_checks++;
        if (ackout !== 1'b0 || count !== 4'd5 || grant !== 2'b00 || busy !== 1'b1 || acks != 0) begin
            n_errors++;
            $display("FAIL abort_release got ack=%b cnt=%0d grant=%b busy=%b prior_acks=%0d exp 0/5/00/1/0",
                     ackout, count, grant, busy, acks);
        end
        req = 2'b00;
        tick();
        req = 2'b11;
        tick();
        n_checks++;
        if (grant !== 2'b10 || obs() !== exp_vec()) begin
            n_errors++; $display("FAIL abort_ptr got grant=%b exp=10", grant);
        end
    endtask

    task automatic test_abort_terminal();
        int acks = 0;
        apply_reset(2'b00);
        limit0 = 4'd2; req = 2'b01;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        req = 2'b00;
        n_checks++;
        if (ackout !== 1'b0 || count !== 4'd1 || obs() !== exp_vec()) begin
            n_errors++; $display("FAIL abort_term got ack=%b cnt=%0d exp ack=0 cnt=1", ackout, count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ackout) acks++;
        end
        n_checks++;
        if (acks != 0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_term_after acks=%0d busy=%b exp acks=0 busy=0", acks, busy);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2'b00);
        limit0 = 4'd10; req = 2'b01;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 11'd0) begin
            n_errors++; $display("FAIL reset_mid got=%b exp=%b", obs(), 11'd0);
        end
        model_reset();
        req = 2'b11;
        #1 reset = 1'b1;
        tick();
        n_checks++;
        if (grant !== 2'b01 || obs() !== exp_vec()) begin
            n_errors++; $display("FAIL reset_mid_grant got=%b exp=01", grant);
        end
    endtask

    task automatic test_random();
        logic prev_ack = 1'b0;
        apply_reset(2'b00);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 3) == 0) req[1] = ~req[1];
            limit0 = 4'($urandom_range(0, 15));
            limit1 = 4'($urandom_range(0, 15));
            abort = ($urandom_range(0, 11) == 0);
            tick();
            n_checks++;
            if (obs() !== exp_vec()) begin
                n_errors++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, obs(), exp_vec());
            end
            if ((prev_ack && ackout) || grant === 2'b11) begin
                n_errors++; $display("FAIL random_invariant t=%0t ack=%b prev=%b grant=%b", $time, ackout, prev_ack, grant);
            end
            prev_ack = ackout;
        end
        abort = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_limit();
        test_abort();
        test_abort_terminal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
